// File: rtl/interrupt_controller_pkg.sv
// Shared CPU definitions for the interrupt controller: FSM state encoding
// and the default location of the vector table.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0010;
    localparam int          ADDR_W           = 16;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit (bit 0 wins) and
// whether any bit is set. Purely combinational.
module priority_encoder #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Walk from the top so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: edge-detected sources, masked fixed
// priority arbitration, vector generation and resume-address capture.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no request outstanding; arbitrating pending & mask
//   ST_REQ     | irq_req asserted, waiting for irq_ack from control FSM
//   ST_SERVICE | handler running, waiting for reti; no nesting
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NIRQ     = 4,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT,
    localparam int         IDW      = $clog2(NIRQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NIRQ-1:0]   irq_lines,
    input  logic              mask_we,
    input  logic [NIRQ-1:0]   mask_wdata,
    input  logic              irq_ack,
    input  logic              reti,
    input  logic [15:0]       pc_resume,
    output logic              irq_req,
    output logic [15:0]       interrupts_addr,
    output logic [15:0]       ret_addr,
    output logic              irq_active,
    output logic [IDW-1:0]    irq_id,
    output logic [NIRQ-1:0]   pending
);

    irq_state_t        state, state_nxt;
    logic [NIRQ-1:0]   edge_q, edge_d;
    logic [NIRQ-1:0]   mask;
    logic [NIRQ-1:0]   rise;
    logic [NIRQ-1:0]   clr;
    logic [IDW-1:0]    enc_idx;
    logic              enc_valid;
    logic              take_req;
    logic              take_ack;

    priority_encoder #(.N(NIRQ), .IDW(IDW)) u_prio (
        .req   (pending & mask),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_req  = 1'b0;
        take_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_nxt = ST_REQ;
                    take_req  = 1'b1;
                end
            end
            ST_REQ: begin
                // Committed: mask changes no longer matter here.
                if (irq_ack) begin
                    state_nxt = ST_SERVICE;
                    take_ack  = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (reti) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Two-stage history so a line high at reset release still reads as a rise.
    assign rise = edge_q & ~edge_d;
    assign clr  = take_ack ? ({{(NIRQ-1){1'b0}}, 1'b1} << irq_id) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_q     <= '0;
            edge_d     <= '0;
            pending    <= '0;
            mask       <= '0;
            irq_id     <= '0;
            ret_addr   <= 16'h0000;
            irq_req    <= 1'b0;
            irq_active <= 1'b0;
        end else begin
            edge_q     <= irq_lines;
            edge_d     <= edge_q;
            // A fresh edge on the bit being acknowledged must survive the clear.
            pending    <= (pending & ~clr) | rise;
            if (mask_we)  mask     <= mask_wdata;
            if (take_req) irq_id   <= enc_idx;
            if (take_ack) ret_addr <= pc_resume;
            irq_req    <= (state_nxt == ST_REQ);
            irq_active <= (state_nxt == ST_SERVICE);
        end
    end

    assign interrupts_addr = VEC_BASE + 16'(irq_id);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

    logic        clock;
    logic        reset;
    logic [3:0]  irq_lines;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        irq_ack;
    logic        reti;
    logic [15:0] pc_resume;
    logic        irq_req;
    logic [15:0] interrupts_addr;
    logic [15:0] ret_addr;
    logic        irq_active;
    logic [1:0]  irq_id;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    interrupt_controller #(.NIRQ(4), .VEC_BASE(16'h0010)) dut (
        .clock           (clock),
        .reset           (reset),
        .irq_lines       (irq_lines),
        .mask_we         (mask_we),
        .mask_wdata      (mask_wdata),
        .irq_ack         (irq_ack),
        .reti            (reti),
        .pc_resume       (pc_resume),
        .irq_req         (irq_req),
        .interrupts_addr (interrupts_addr),
        .ret_addr        (ret_addr),
        .irq_active      (irq_active),
        .irq_id          (irq_id),
        .pending         (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        irq_lines = '0; mask_we = 1'b0; mask_wdata = '0;
        irq_ack = 1'b0; reti = 1'b0; pc_resume = '0;
        #12;
        total++; if (irq_req !== 1'b0)          begin bad++; $display("FAIL rst_irq_req got=%b exp=0", irq_req); end
        total++; if (irq_active !== 1'b0)       begin bad++; $display("FAIL rst_irq_active got=%b exp=0", irq_active); end
        total++; if (irq_id !== 2'd0)           begin bad++; $display("FAIL rst_irq_id got=%0d exp=0", irq_id); end
        total++; if (pending !== 4'b0000)       begin bad++; $display("FAIL rst_pending got=%b exp=0000", pending); end
        total++; if (ret_addr !== 16'h0000)     begin bad++; $display("FAIL rst_ret_addr got=%h exp=0000", ret_addr); end
        total++; if (interrupts_addr !== 16'h0010) begin bad++; $display("FAIL rst_vec got=%h exp=0010", interrupts_addr); end
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_mask(4'b0100);
        irq_lines = 4'b0100;
        tick();
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL single_pend_c1 got=%b exp=0000", pending); end
        tick();
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pend_c2 got=%b exp=0100", pending); end
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL single_req_c2 got=%b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL single_req_c3 got=%b exp=1", irq_req); end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("FAIL single_id got=%0d exp=2", irq_id); end
        total++; if (interrupts_addr !== 16'h0012) begin bad++; $display("FAIL single_vec got=%h exp=0012", interrupts_addr); end
        irq_ack = 1'b1; pc_resume = 16'h0042;
        tick();
        irq_ack = 1'b0;
        total++; if (ret_addr !== 16'h0042) begin bad++; $display("FAIL ack_ret_addr got=%h exp=0042", ret_addr); end
        total++; if (irq_active !== 1'b1)   begin bad++; $display("FAIL ack_active got=%b exp=1", irq_active); end
        total++; if (pending !== 4'b0000)   begin bad++; $display("FAIL ack_pending got=%b exp=0000", pending); end
        total++; if (irq_req !== 1'b0)      begin bad++; $display("FAIL ack_req got=%b exp=0", irq_req); end
        tick();
        total++; if (interrupts_addr !== 16'h0012) begin bad++; $display("FAIL svc_vec_hold got=%h exp=0012", interrupts_addr); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        total++; if (irq_active !== 1'b0)   begin bad++; $display("FAIL reti_active got=%b exp=0", irq_active); end
        total++; if (ret_addr !== 16'h0042) begin bad++; $display("FAIL reti_ret_hold got=%h exp=0042", ret_addr); end
        irq_lines = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_priority();
        write_mask(4'b1111);
        irq_lines = 4'b1010;
        tick(); tick();
        total++; if (pending !== 4'b1010) begin bad++; $display("FAIL prio_pending got=%b exp=1010", pending); end
        tick();
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL prio_req1 got=%b exp=1", irq_req); end
        total++; if (irq_id !== 2'd1)     begin bad++; $display("FAIL prio_id1 got=%0d exp=1", irq_id); end
        total++; if (interrupts_addr !== 16'h0011) begin bad++; $display("FAIL prio_vec1 got=%h exp=0011", interrupts_addr); end
        irq_ack = 1'b1; pc_resume = 16'h0100;
        tick();
        irq_ack = 1'b0;
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL prio_pend_after_ack got=%b exp=1000", pending); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL prio_req_idle got=%b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL prio_req2 got=%b exp=1", irq_req); end
        total++; if (irq_id !== 2'd3)     begin bad++; $display("FAIL prio_id2 got=%0d exp=3", irq_id); end
        total++; if (interrupts_addr !== 16'h0013) begin bad++; $display("FAIL prio_vec2 got=%h exp=0013", interrupts_addr); end
        irq_ack = 1'b1; pc_resume = 16'h0101;
        tick();
        irq_ack = 1'b0;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        irq_lines = 4'b0000;
        tick(); tick(); tick();
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL prio_pending_end got=%b exp=0000", pending); end
    endtask

    task automatic test_nesting();
        irq_lines = 4'b0100;
        tick(); tick(); tick();
        irq_ack = 1'b1; pc_resume = 16'h0200;
        tick();
        irq_ack = 1'b0;
        irq_lines = 4'b0101;
        tick(); tick();
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL nest_pending got=%b exp=0001", pending); end
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL nest_req_svc got=%b exp=0", irq_req); end
        tick(); tick();
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL nest_req_svc2 got=%b exp=0", irq_req); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL nest_req_reti got=%b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL nest_req_after got=%b exp=1", irq_req); end
        total++; if (irq_id !== 2'd0)     begin bad++; $display("FAIL nest_id got=%0d exp=0", irq_id); end
        // Masking the committed request must not withdraw it.
        write_mask(4'b0000);
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL commit_req got=%b exp=1", irq_req); end
        irq_ack = 1'b1; pc_resume = 16'h0077;
        tick();
        irq_ack = 1'b0;
        total++; if (irq_active !== 1'b1) begin bad++; $display("FAIL commit_active got=%b exp=1", irq_active); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        irq_lines = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_masked();
        irq_lines = 4'b0001;
        tick(); tick();
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL mask_pending got=%b exp=0001", pending); end
        irq_ack = 1'b1; reti = 1'b1; pc_resume = 16'hBEEF;
        tick();
        irq_ack = 1'b0; reti = 1'b0;
        total++; if (ret_addr !== 16'h0077) begin bad++; $display("FAIL idle_ack_ignored got=%h exp=0077", ret_addr); end
        total++; if (irq_active !== 1'b0)   begin bad++; $display("FAIL idle_active got=%b exp=0", irq_active); end
        tick(); tick();
        total++; if (irq_req !== 1'b0)      begin bad++; $display("FAIL mask_no_req got=%b exp=0", irq_req); end
        write_mask(4'b0001);
        total++; if (irq_req !== 1'b0)      begin bad++; $display("FAIL mask_req_c1 got=%b exp=0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1)      begin bad++; $display("FAIL mask_req_c2 got=%b exp=1", irq_req); end
        irq_ack = 1'b1; pc_resume = 16'h0300;
        tick();
        irq_ack = 1'b0;
        total++; if (irq_active !== 1'b1)   begin bad++; $display("FAIL mask_active got=%b exp=1", irq_active); end
    endtask

    task automatic test_reset_service();
        #1;
        reset = 1'b0;
        irq_lines = 4'b1000;
        #1;
        total++; if (irq_req !== 1'b0)          begin bad++; $display("FAIL rsvc_req got=%b exp=0", irq_req); end
        total++; if (irq_active !== 1'b0)       begin bad++; $display("FAIL rsvc_active got=%b exp=0", irq_active); end
        total++; if (irq_id !== 2'd0)           begin bad++; $display("FAIL rsvc_id got=%0d exp=0", irq_id); end
        total++; if (pending !== 4'b0000)       begin bad++; $display("FAIL rsvc_pending got=%b exp=0000", pending); end
        total++; if (ret_addr !== 16'h0000)     begin bad++; $display("FAIL rsvc_ret got=%h exp=0000", ret_addr); end
        total++; if (interrupts_addr !== 16'h0010) begin bad++; $display("FAIL rsvc_vec got=%h exp=0010", interrupts_addr); end
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL hold_pend_c1 got=%b exp=0000", pending); end
        tick();
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL hold_pend_c2 got=%b exp=1000", pending); end
        tick();
        total++; if (irq_req !== 1'b0)    begin bad++; $display("FAIL hold_masked got=%b exp=0", irq_req); end
        write_mask(4'b1000);
        tick();
        total++; if (irq_req !== 1'b1)    begin bad++; $display("FAIL hold_req got=%b exp=1", irq_req); end
        total++; if (interrupts_addr !== 16'h0013) begin bad++; $display("FAIL hold_vec got=%h exp=0013", interrupts_addr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_masked();
        test_reset_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
